// File: rtl/counter_read_arbiter.sv
// Round-robin arbiter that shares the 64-bit atomic counter's 32-bit read port and returns coherent 64-bit reads.
// Optional CNT_ACK_CHECK_EN: a missing counter ack sets sticky ack_err_o and suppresses that completion.
module counter_read_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATABUS  = 32,
    parameter int COUNTLEN = 2 * DATABUS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         rd_req_i,
    output logic                       rd_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] rd_id_o,
    output logic [COUNTLEN-1:0]        rd_data_o,
    output logic                       busy_o,
    output logic                       cnt_req_o,
    output logic                       cnt_atomic_o,
    input  logic                       cnt_ack_i,
    input  logic [DATABUS-1:0]         cnt_data_i,
    output logic                       ack_err_o
);
    localparam int IDW = $clog2(NUM_REQ);

`ifdef CNT_ACK_CHECK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_LSB, S_MSB, S_CAP} state_e;

    state_e                state_q, state_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [IDW-1:0]        gid_q, gid_d;
    logic [DATABUS-1:0]    lsb_q, lsb_d;
    logic                  miss_q, miss_d;
    logic                  err_q, err_d;
    logic                  vld_q, vld_d;
    logic [IDW-1:0]        id_q, id_d;
    logic [COUNTLEN-1:0]   data_q, data_d;

    logic [NUM_REQ-1:0]    upper_mask;
    logic [NUM_REQ-1:0]    upper_req;
    logic [IDW-1:0]        pick;
    logic                  ack_take;

    function automatic logic [IDW-1:0] lowest(input logic [NUM_REQ-1:0] v);
        logic [IDW-1:0] r;
        r = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) r = IDW'(i);
        end
        return r;
    endfunction

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == IDW'(NUM_REQ - 1)) ? '0 : id + IDW'(1);
    endfunction

    // Requests at or above the pointer win; otherwise wrap to the lowest set bit.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_mask
        assign upper_mask[g] = (IDW'(g) >= ptr_q);
    end

    assign upper_req = rd_req_i & upper_mask;
    assign pick      = (|upper_req) ? lowest(upper_req) : lowest(rd_req_i);
    // Without the check, every MSB/CAP cycle is treated as carrying data.
    assign ack_take  = cnt_ack_i || !ACK_CHK;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gid_d        = gid_q;
        lsb_d        = lsb_q;
        miss_d       = miss_q;
        err_d        = err_q;
        vld_d        = 1'b0;
        id_d         = id_q;
        data_d       = data_q;
        cnt_req_o    = 1'b0;
        cnt_atomic_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|rd_req_i) begin
                    gid_d   = pick;
                    miss_d  = 1'b0;
                    state_d = S_LSB;
                end
            end
            S_LSB: begin
                cnt_req_o    = 1'b1;
                cnt_atomic_o = 1'b1;
                state_d      = S_MSB;
            end
            S_MSB: begin
                // MSB beat must follow LSB with no bubble so both halves share one snapshot.
                cnt_req_o = 1'b1;
                state_d   = S_CAP;
                if (ack_take) begin
                    lsb_d = cnt_data_i;
                end else begin
                    miss_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            S_CAP: begin
                state_d = S_IDLE;
                ptr_d   = next_id(gid_q);
                if (!ack_take) err_d = 1'b1;
                if (ack_take && !miss_q) begin
                    vld_d  = 1'b1;
                    id_d   = gid_q;
                    data_d = {cnt_data_i, lsb_q};
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            lsb_q   <= '0;
            miss_q  <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            lsb_q   <= lsb_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
            data_q  <= data_d;
        end
    end

    assign rd_valid_o = vld_q;
    assign rd_id_o    = id_q;
    assign rd_data_o  = data_q;
    assign busy_o     = (state_q != S_IDLE);
    assign ack_err_o  = ACK_CHK ? err_q : 1'b0;

endmodule

// File: tb/tb_counter_read_arbiter.sv
// Bench for counter_read_arbiter: directed tables and sequences plus random traffic against a transaction-level model.
module tb_counter_read_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [N-1:0] rd_req_i;
    logic        rd_valid_o;
    logic [1:0]  rd_id_o;
    logic [63:0] rd_data_o;
    logic        busy_o;
    logic        cnt_req_o;
    logic        cnt_atomic_o;
    logic        cnt_ack_i;
    logic [31:0] cnt_data_i;
    logic        ack_err_o;

    int tests = 0;
    int fails = 0;

    counter_read_arbiter #(.NUM_REQ(N), .DATABUS(32), .COUNTLEN(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_req_i     (rd_req_i),
        .rd_valid_o   (rd_valid_o),
        .rd_id_o      (rd_id_o),
        .rd_data_o    (rd_data_o),
        .busy_o       (busy_o),
        .cnt_req_o    (cnt_req_o),
        .cnt_atomic_o (cnt_atomic_o),
        .cnt_ack_i    (cnt_ack_i),
        .cnt_data_i   (cnt_data_i),
        .ack_err_o    (ack_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Counter model: free-running 64-bit count, snapshot on the atomic beat, ack one cycle after each request.
    logic [63:0] cnt64 = 64'h0;
    logic [63:0] snap  = 64'h0;
    logic        pend_lsb = 1'b0;
    logic        pend_msb = 1'b0;
    bit          drop_cap_ack = 1'b0;

    always @(negedge clk) begin
        pend_lsb = cnt_req_o && cnt_atomic_o && !reset;
        pend_msb = cnt_req_o && !cnt_atomic_o && !reset;
        if (pend_lsb) snap = cnt64;
    end

    always @(posedge clk) begin
        #1;
        cnt64 = cnt64 + 64'd1;
        if (pend_lsb) begin
            cnt_ack_i  = 1'b1;
            cnt_data_i = snap[31:0];
        end else if (pend_msb) begin
            cnt_ack_i  = !drop_cap_ack;
            cnt_data_i = snap[63:32];
        end else begin
            cnt_ack_i  = 1'($urandom_range(1));
            cnt_data_i = $urandom;
        end
    end

    // Reference model: a transaction takes 3 busy cycles; the result appears the cycle after.
    int          ph = 0;
    int          m_ptr = 0;
    int          m_gid = 0;
    logic [63:0] m_snap = 64'h0;
    logic [63:0] m_data = 64'h0;
    logic [1:0]  m_id = 2'd0;
    logic        m_vld = 1'b0;
    logic        m_err = 1'b0;
    logic        m_miss = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            ph = 0; m_ptr = 0; m_gid = 0; m_vld = 1'b0; m_data = 64'h0; m_id = 2'd0; m_err = 1'b0; m_miss = 1'b0;
        end else begin
            chk("busy", 64'(busy_o), 64'(ph != 0));
            chk("cnt_req", 64'(cnt_req_o), 64'(ph == 1 || ph == 2));
            chk("cnt_atomic", 64'(cnt_atomic_o), 64'(ph == 1));
            chk("rd_valid", 64'(rd_valid_o), 64'(m_vld));
            chk("rd_id", 64'(rd_id_o), 64'(m_id));
            chk("rd_data", rd_data_o, m_data);
            chk("ack_err", 64'(ack_err_o), 64'(m_err));
            m_vld = 1'b0;
            case (ph)
                0: if (rd_req_i != '0) begin
                    bit found;
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && rd_req_i[(m_ptr + k) % N]) begin
                            m_gid = (m_ptr + k) % N;
                            found = 1'b1;
                        end
                    end
                    m_miss = 1'b0;
                    ph = 1;
                end
                1: begin m_snap = cnt64; ph = 2; end
                2: begin if (!cnt_ack_i) m_miss = 1'b1; ph = 3; end
                3: begin
                    if (!cnt_ack_i) m_miss = 1'b1;
`ifdef CNT_ACK_CHECK_EN
                    if (m_miss) m_err = 1'b1;
`else
                    m_miss = 1'b0;
`endif
                    if (!m_miss) begin
                        m_vld = 1'b1; m_id = 2'(m_gid); m_data = m_snap;
                    end
                    m_ptr = (m_gid + 1) % N;
                    ph = 0;
                end
                default: ph = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int maxc, output int lat, output bit ok);
        lat = 0; ok = 1'b0;
        while (!ok && lat < maxc) begin
            step();
            lat++;
            ok = rd_valid_o;
        end
    endtask

    task automatic serve(input logic [N-1:0] req, input int exp_id, input string nm);
        int lat; bit ok;
        rd_req_i = req;
        wait_valid(10, lat, ok);
        chk({nm, "_valid"}, 64'(ok), 64'd1);
        chk({nm, "_latency"}, 64'(lat), 64'd4);
        chk({nm, "_id"}, 64'(rd_id_o), 64'(exp_id));
        rd_req_i = '0;
    endtask

    task automatic rr_round(input int e0, input int e1, input int e2, input int e3);
        int exp_ids[4]; int lat; bit ok;
        exp_ids = '{e0, e1, e2, e3};
        rd_req_i = '1;
        for (int i = 0; i < 4; i++) begin
            wait_valid(10, lat, ok);
            chk("rr_valid", 64'(ok), 64'd1);
            chk("rr_spacing", 64'(lat), 64'd4);
            chk("rr_id", 64'(rd_id_o), 64'(exp_ids[i]));
            if (ok) rd_req_i[rd_id_o] = 1'b0;
        end
        rd_req_i = '0;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    typedef struct {
        logic [N-1:0] req;
        int           exp_id;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   lat, nvld;
        bit   ok;

        // Pointer starts at 3 after the single read (requester 2).
        tbl[0] = '{4'b1111, 3};
        tbl[1] = '{4'b0011, 0};
        tbl[2] = '{4'b0011, 1};
        tbl[3] = '{4'b0001, 0};
        tbl[4] = '{4'b1000, 3};
        tbl[5] = '{4'b1001, 0};
        tbl[6] = '{4'b0110, 1};
        tbl[7] = '{4'b0100, 2};

        reset = 1'b1; rd_req_i = '0; cnt_ack_i = 1'b0; cnt_data_i = '0;
        step(); step();
        chk("rst_valid", 64'(rd_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_cnt_req", 64'(cnt_req_o), 64'd0);
        chk("rst_data", rd_data_o, 64'd0);
        chk("rst_id", 64'(rd_id_o), 64'd0);
        chk("rst_ack_err", 64'(ack_err_o), 64'd0);
        reset = 1'b0;
        step();

        // Single read across the 32-bit carry.
        cnt64 = 64'h0000_0001_FFFF_FFFE;
        rd_req_i = 4'b0100;
        wait_valid(10, lat, ok);
        chk("single_valid", 64'(ok), 64'd1);
        chk("single_latency", 64'(lat), 64'd4);
        chk("single_id", 64'(rd_id_o), 64'd2);
        chk("single_data", rd_data_o, 64'h0000_0001_FFFF_FFFF);
        rd_req_i = '0;
        step();
        chk("single_data_hold", rd_data_o, 64'h0000_0001_FFFF_FFFF);

        for (int i = 0; i < 8; i++) begin
            serve(tbl[i].req, tbl[i].exp_id, $sformatf("tbl%0d", i));
        end

        // Requester 3 drops in LSB, requester 1 pulses only in MSB.
        rd_req_i = 4'b1000;
        step();
        chk("drop_lsb_phase", 64'({cnt_req_o, cnt_atomic_o}), 64'd3);
        rd_req_i = 4'b0000;
        step();
        chk("drop_msb_phase", 64'({cnt_req_o, cnt_atomic_o}), 64'd2);
        rd_req_i = 4'b0010;
        step();
        rd_req_i = 4'b0000;
        step();
        chk("drop_valid", 64'(rd_valid_o), 64'd1);
        chk("drop_id", 64'(rd_id_o), 64'd3);
        nvld = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rd_valid_o) nvld++;
        end
        chk("drop_unserved", 64'(nvld), 64'd0);

        // Reset during MSB with a non-zero pointer.
        serve(4'b0010, 1, "pre_rst");
        rd_req_i = 4'b0100;
        lat = 0;
        while (!(cnt_req_o && !cnt_atomic_o) && lat < 6) begin
            step();
            lat++;
        end
        chk("rst_reach_msb", 64'(cnt_req_o && !cnt_atomic_o), 64'd1);
        rd_req_i = '0;
        #1 reset = 1'b1;
        #1;
        chk("midrst_valid", 64'(rd_valid_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_cnt", 64'({cnt_req_o, cnt_atomic_o}), 64'd0);
        chk("midrst_id", 64'(rd_id_o), 64'd0);
        chk("midrst_data", rd_data_o, 64'd0);
        step(); step();
        reset = 1'b0;
        nvld = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rd_valid_o) nvld++;
        end
        chk("midrst_no_valid", 64'(nvld), 64'd0);
        serve(4'b1001, 0, "post_rst");

        reset_pulse();
        rr_round(0, 1, 2, 3);
        serve(4'b0001, 0, "rr_setup");
        rr_round(1, 2, 3, 0);

        // Missing ack in CAP (pointer is 1, so requester 2 is granted).
        drop_cap_ack = 1'b1;
        rd_req_i = 4'b0100;
        step();
        rd_req_i = '0;
        nvld = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (rd_valid_o) nvld++;
        end
        drop_cap_ack = 1'b0;
`ifdef CNT_ACK_CHECK_EN
        chk("ackerr_no_valid", 64'(nvld), 64'd0);
        chk("ackerr_set", 64'(ack_err_o), 64'd1);
`else
        chk("ackerr_valid", 64'(nvld), 64'd1);
        chk("ackerr_tied", 64'(ack_err_o), 64'd0);
`endif
        serve(4'b0010, 1, "after_ackerr");
`ifdef CNT_ACK_CHECK_EN
        chk("ackerr_sticky", 64'(ack_err_o), 64'd1);
`else
        chk("ackerr_still0", 64'(ack_err_o), 64'd0);
`endif

        // Random traffic obeying the requester rules; the model checks every cycle.
        for (int c = 0; c < 500; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (rd_valid_o && int'(rd_id_o) == i) rd_req_i[i] = 1'b0;
                else if (!rd_req_i[i] && $urandom_range(3) == 0) rd_req_i[i] = 1'b1;
                else if (rd_req_i[i] && $urandom_range(15) == 0) rd_req_i[i] = 1'b0;
            end
            drop_cap_ack = ($urandom_range(7) == 0);
        end
        rd_req_i = '0;
        drop_cap_ack = 1'b0;
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
